// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared defaults, counter states and table entry type
package branch_predictor_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_ENTRIES = 8;
  localparam int DEF_STAT_W  = 16;

  // Storage width of the tag/target fields; ADDR_W must not exceed it.
  localparam int PC_MAX_W = DEF_ADDR_W;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [PC_MAX_W-1:0] tag;
    logic [PC_MAX_W-1:0] target;
    logic [1:0]          ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - 2-bit saturating direction counter update
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (taken && (state != ST)) begin
      next_state = state + 2'b01;
    end else if (!taken && (state != SNT)) begin
      next_state = state - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and mispredict stats
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int STAT_W  = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_pc,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_pc,
  output logic              mispredict,
  output logic [ADDR_W-1:0] recover_pc,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mis_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t         r_tab [ENTRIES];
  logic [STAT_W-1:0] r_br_cnt;
  logic [STAT_W-1:0] r_mis_cnt;

  logic [IDX_W-1:0]    w_if_idx;
  logic [IDX_W-1:0]    w_ex_idx;
  logic [PC_MAX_W-1:0] w_if_tag;
  logic [PC_MAX_W-1:0] w_ex_tag;
  bp_entry_t           w_if_ent;
  bp_entry_t           w_ex_ent;
  logic                w_if_hit;
  logic                w_ex_hit;
  logic [1:0]          w_ex_ctr_nxt;

  assign w_if_idx = if_pc[IDX_W-1:0];
  assign w_ex_idx = ex_pc[IDX_W-1:0];
  assign w_if_tag = PC_MAX_W'(if_pc >> IDX_W);
  assign w_ex_tag = PC_MAX_W'(ex_pc >> IDX_W);
  assign w_if_ent = r_tab[w_if_idx];
  assign w_ex_ent = r_tab[w_ex_idx];
  assign w_if_hit = w_if_ent.valid && (w_if_ent.tag == w_if_tag);
  assign w_ex_hit = w_ex_ent.valid && (w_ex_ent.tag == w_ex_tag);

  // Lookup reads registered contents only, so a same-cycle update is not bypassed.
  assign pred_taken = w_if_hit && w_if_ent.ctr[1];
  assign pred_pc    = pred_taken ? w_if_ent.target[ADDR_W-1:0] : if_pc + ADDR_W'(1);

  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && ex_pred_taken && (ex_target != ex_pred_pc)));
  assign recover_pc = ex_taken ? ex_target : ex_pc + ADDR_W'(1);

  bp_sat_counter u_ctr (
    .state      (w_ex_ent.ctr),
    .taken      (ex_taken),
    .next_state (w_ex_ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tab[i] <= '0;
      end
    end else if (en) begin
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          r_tab[i].valid <= 1'b0;
        end
      end else if (ex_valid) begin
        if (w_ex_hit) begin
          r_tab[w_ex_idx].ctr <= w_ex_ctr_nxt;
          if (ex_taken) begin
            r_tab[w_ex_idx].target <= PC_MAX_W'(ex_target);
          end
        end else if (ex_taken) begin
          r_tab[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag,
                               target: PC_MAX_W'(ex_target), ctr: WT};
        end
      end
    end
  end

  // Statistics keep counting through a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (en && ex_valid) begin
      if (r_br_cnt != '1) begin
        r_br_cnt <= r_br_cnt + STAT_W'(1);
      end
      if (mispredict && (r_mis_cnt != '1)) begin
        r_mis_cnt <= r_mis_cnt + STAT_W'(1);
      end
    end
  end

  assign br_cnt  = r_br_cnt;
  assign mis_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] if_pc = '0;
  logic        pred_taken;
  logic [15:0] pred_pc;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [15:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [15:0] ex_pred_pc = '0;
  logic        mispredict;
  logic [15:0] recover_pc;
  logic [3:0]  br_cnt;
  logic [3:0]  mis_cnt;

  branch_predictor #(.ADDR_W(16), .ENTRIES(8), .STAT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_pc(pred_pc), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
    .mispredict(mispredict), .recover_pc(recover_pc),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] M_PT = 6'd1, M_PPC = 6'd2, M_MIS = 6'd4,
                         M_RPC = 6'd8, M_BR = 6'd16, M_MC = 6'd32;

  typedef struct {
    string       name;
    logic [5:0]  m;
    logic        pt;
    logic [15:0] ppc;
    logic        mis;
    logic [15:0] rpc;
    logic [3:0]  br;
    logic [3:0]  mc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%04h expected 0x%04h", name, fld, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so drain the expectations at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) chk(e.name, "pred_taken", 16'(pred_taken), 16'(e.pt));
      if (e.m[1]) chk(e.name, "pred_pc", pred_pc, e.ppc);
      if (e.m[2]) chk(e.name, "mispredict", 16'(mispredict), 16'(e.mis));
      if (e.m[3]) chk(e.name, "recover_pc", recover_pc, e.rpc);
      if (e.m[4]) chk(e.name, "br_cnt", 16'(br_cnt), 16'(e.br));
      if (e.m[5]) chk(e.name, "mis_cnt", 16'(mis_cnt), 16'(e.mc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e_en, input logic e_fl, input logic [15:0] ipc,
                       input logic xv, input logic [15:0] xpc, input logic xt,
                       input logic [15:0] xtgt, input logic xpt, input logic [15:0] xppc);
    en = e_en; flush = e_fl; if_pc = ipc; ex_valid = xv; ex_pc = xpc;
    ex_taken = xt; ex_target = xtgt; ex_pred_taken = xpt; ex_pred_pc = xppc;
  endtask

  task automatic exp_push(input string name, input logic [5:0] m, input logic pt,
                          input logic [15:0] ppc, input logic mis, input logic [15:0] rpc,
                          input logic [3:0] br, input logic [3:0] mc);
    exp_t e;
    e.name = name; e.m = m; e.pt = pt; e.ppc = ppc; e.mis = mis; e.rpc = rpc;
    e.br = br; e.mc = mc;
    q.push_back(e);
  endtask

  localparam logic [5:0] M_LK = M_PT | M_PPC;
  localparam logic [5:0] M_EX = M_MIS | M_RPC;
  localparam logic [5:0] M_ST = M_BR | M_MC;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst = 1'b1;
    drive(1, 0, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("reset", M_LK | M_EX | M_ST, 0, 16'h0041, 0, 16'h0001, 0, 0);

    tick(); drive(1, 0, 16'h0010, 1, 16'h0010, 1, 16'h0030, 0, 16'h0000);
    exp_push("first_alloc", M_LK | M_EX, 0, 16'h0011, 1, 16'h0030, 0, 0);
    tick(); drive(1, 0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("after_alloc", M_LK | M_MIS | M_ST, 1, 16'h0030, 0, 0, 1, 1);

    tick(); drive(1, 0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 16'h0030);
    exp_push("nt_res", M_LK | M_EX, 1, 16'h0030, 1, 16'h0011, 1, 1);
    tick(); drive(1, 0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("weak_nt", M_LK | M_ST, 0, 16'h0011, 0, 0, 2, 2);
    tick(); drive(1, 0, 16'h0010, 1, 16'h0010, 1, 16'h0030, 0, 16'h0011);
    exp_push("tk1", M_EX, 0, 0, 1, 16'h0030, 0, 0);
    tick(); drive(1, 0, 16'h0010, 1, 16'h0010, 1, 16'h0030, 1, 16'h0030);
    exp_push("tk2", M_LK | M_EX | M_ST, 1, 16'h0030, 0, 16'h0030, 3, 3);
    tick(); drive(1, 0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 16'h0030);
    exp_push("nt_strong", M_EX | M_ST, 0, 0, 1, 16'h0011, 4, 3);
    tick(); drive(1, 0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("hysteresis", M_LK | M_ST, 1, 16'h0030, 0, 0, 5, 4);

    tick(); drive(1, 0, 16'h0010, 1, 16'h0010, 1, 16'h0050, 1, 16'h0030);
    exp_push("bad_target", M_EX, 0, 0, 1, 16'h0050, 0, 0);
    tick(); drive(1, 0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("new_target", M_LK | M_ST, 1, 16'h0050, 0, 0, 6, 5);

    tick(); drive(1, 0, 16'h0010, 1, 16'h0018, 1, 16'h0070, 0, 16'h0000);
    exp_push("alias_alloc", M_EX, 0, 0, 1, 16'h0070, 0, 0);
    tick(); drive(1, 0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("alias_miss", M_LK | M_ST, 0, 16'h0011, 0, 0, 7, 6);
    tick(); drive(1, 0, 16'h0018, 1, 16'h0028, 0, 16'h0000, 0, 16'h0000);
    exp_push("alias_hit", M_LK | M_EX, 1, 16'h0070, 0, 16'h0029, 0, 0);
    tick(); drive(1, 0, 16'h0018, 1, 16'h0003, 1, 16'h0099, 0, 16'h0000);
    exp_push("miss_nt_keep", M_LK | M_EX | M_ST, 1, 16'h0070, 1, 16'h0099, 8, 6);

    tick(); drive(1, 1, 16'h0003, 1, 16'h0020, 1, 16'h0044, 0, 16'h0000);
    exp_push("flush_cyc", M_LK | M_EX | M_ST, 1, 16'h0099, 1, 16'h0044, 9, 7);
    tick(); drive(1, 0, 16'h0003, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("flush_idx3", M_LK | M_ST, 0, 16'h0004, 0, 0, 10, 8);
    tick(); if_pc = 16'h0020;
    exp_push("flush_no_alloc", M_LK, 0, 16'h0021, 0, 0, 0, 0);
    tick(); if_pc = 16'h0018;
    exp_push("flush_idx0", M_LK, 0, 16'h0019, 0, 0, 0, 0);

    tick(); drive(0, 0, 16'h0010, 1, 16'h0010, 1, 16'h0030, 0, 16'h0000);
    exp_push("hold_mis", M_EX | M_ST, 0, 0, 1, 16'h0030, 10, 8);
    tick(); drive(1, 0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("hold_state", M_LK | M_ST, 0, 16'h0011, 0, 0, 10, 8);

    tick(); drive(1, 0, 16'h0010, 1, 16'h0010, 1, 16'h0030, 0, 16'h0000);
    rst = 1'b0;
    exp_push("reset_async", M_LK | M_ST, 0, 16'h0011, 0, 0, 0, 0);
    tick(); rst = 1'b1;
    drive(1, 0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("reset_discard", M_LK | M_ST, 0, 16'h0011, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      tick(); drive(1, 0, 16'h0040, 1, 16'h0010, 1, 16'h0030, 0, 16'h0000);
    end
    tick(); drive(1, 0, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    exp_push("saturate", M_ST, 0, 0, 0, 0, 15, 15);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
